// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode type, reset defaults and duty-bus helper for pwm_multi_gen
package pwm_pkg;

  typedef enum logic {EDGE = 1'b0, CENTER = 1'b1} pwm_mode_e;

  localparam logic [12:0] PRESC_RST_DEF  = 13'h9C4;
  localparam logic [11:0] PERIOD_RST_DEF = 12'd99;
  localparam int          DUTY_BUS_MAX   = 1024;

`ifdef PWM_CENTER_ALIGNED_EN
  localparam pwm_mode_e PWM_MODE = CENTER;
`else
  localparam pwm_mode_e PWM_MODE = EDGE;
`endif

  // Extract field idx of width w from a flat duty bus (zero-extended to DUTY_BUS_MAX).
  function automatic logic [31:0] duty_slice(input logic [DUTY_BUS_MAX-1:0] bus, input int idx, input int w);
    logic [DUTY_BUS_MAX-1:0] s;
    s = bus >> (idx * w);
    return s[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clkin by max(presc_i,1) and emits a one-cycle tick at the last count
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESC_W = 13
) (
  input  logic               clkin,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q, cnt_d, eff;

  // A zero divide value is treated as one; the >= keeps the count bounded if the divider shrinks.
  always_comb begin
    eff    = (presc_i == '0) ? PRESC_W'(1) : presc_i;
    tick_o = en_i & (cnt_q >= eff - 1'b1);
    cnt_d  = (~en_i | tick_o) ? '0 : cnt_q + 1'b1;
  end

  // Prescaler count register.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: multi-channel PWM with prescaler, shared period counter and shadowed config; PWM_CENTER_ALIGNED_EN selects up/down counting
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int                 CH         = 4,
  parameter int                 CNT_W      = 12,
  parameter int                 PRESC_W    = 13,
  parameter logic [PRESC_W-1:0] PRESC_RST  = PRESC_W'(PRESC_RST_DEF),
  parameter logic [CNT_W-1:0]   PERIOD_RST = CNT_W'(PERIOD_RST_DEF)
) (
  input  logic                clkin,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                load,
  input  logic [PRESC_W-1:0]  presc_top,
  input  logic [CNT_W-1:0]    period,
  input  logic [CH*CNT_W-1:0] duty,
  output logic [CH-1:0]       pwm_out,
  output logic                period_tick,
  output logic                pending
);

  logic [PRESC_W-1:0]          presc_q, presc_d, p_presc_q, p_presc_d;
  logic [CNT_W-1:0]            period_q, period_d, p_period_q, p_period_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CH-1:0][CNT_W-1:0]    duty_in, duty_q, duty_d, p_duty_q, p_duty_d;
  logic [CH-1:0]               pwm_q, pwm_d;
  logic                        pending_q, pending_d, period_tick_q;
  logic                        tick, wrap, apply;
`ifdef PWM_CENTER_ALIGNED_EN
  logic                        dir_q, dir_d, turn;
`endif

  pwm_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clkin  (clkin),
    .rst_n  (rst_n),
    .en_i   (enable),
    .presc_i(presc_q),
    .tick_o (tick)
  );

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign duty_in[i] = CNT_W'(duty_slice(DUTY_BUS_MAX'(duty), i, CNT_W));
    assign pwm_d[i]   = enable & (cnt_q < duty_q[i]);
  end

`ifdef PWM_CENTER_ALIGNED_EN
  // Up/down count dwelling one tick at each end so pulses stay symmetric; wrap only at the bottom.
  always_comb begin
    wrap  = tick & ((period_q == '0) | (dir_q & (cnt_q == '0)));
    turn  = tick & ~dir_q & (period_q != '0) & (cnt_q >= period_q - 1'b1);
    dir_d = (~enable | wrap) ? 1'b0 : turn ? 1'b1 : dir_q;
    cnt_d = (~enable | wrap) ? '0 : (~tick | turn) ? cnt_q : dir_q ? cnt_q - 1'b1 : cnt_q + 1'b1;
  end

  // Count direction register.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) dir_q <= 1'b0;
    else        dir_q <= dir_d;
  end
`else
  // Edge-aligned count 0..period inclusive, advancing on prescaler ticks.
  always_comb begin
    wrap  = tick & (cnt_q >= period_q);
    cnt_d = (~enable | wrap) ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
  end
`endif

  // Shadow update: apply at wrap or while idle; a coincident load bypasses the pending stage.
  always_comb begin
    apply      = wrap | ~enable;
    presc_d    = !apply ? presc_q  : load ? presc_top : pending_q ? p_presc_q  : presc_q;
    period_d   = !apply ? period_q : load ? period    : pending_q ? p_period_q : period_q;
    duty_d     = !apply ? duty_q   : load ? duty_in   : pending_q ? p_duty_q   : duty_q;
    p_presc_d  = (load & ~apply) ? presc_top : p_presc_q;
    p_period_d = (load & ~apply) ? period    : p_period_q;
    p_duty_d   = (load & ~apply) ? duty_in   : p_duty_q;
    pending_d  = ~apply & (load | pending_q);
  end

  // Configuration, counter and registered outputs.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= PRESC_RST;
      period_q      <= PERIOD_RST;
      duty_q        <= '0;
      p_presc_q     <= '0;
      p_period_q    <= '0;
      p_duty_q      <= '0;
      pending_q     <= 1'b0;
      cnt_q         <= '0;
      pwm_q         <= '0;
      period_tick_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      period_q      <= period_d;
      duty_q        <= duty_d;
      p_presc_q     <= p_presc_d;
      p_period_q    <= p_period_d;
      p_duty_q      <= p_duty_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      pwm_q         <= pwm_d;
      period_tick_q <= wrap;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = period_tick_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb_pwm_multi_gen: directed plus random stimulus against an elapsed-cycle reference model
module tb_pwm_multi_gen;

  localparam int CH = 4, CNT_W = 12, PRESC_W = 13;

  logic                clkin = 1'b0, rst_n = 1'b1, enable = 1'b0, load = 1'b0;
  logic [PRESC_W-1:0]  presc_top = '0;
  logic [CNT_W-1:0]    period = '0;
  logic [CH*CNT_W-1:0] duty = '0;
  logic [CH-1:0]       pwm_out;
  logic                period_tick, pending;

  int checks = 0, errors = 0;

  // Reference model: active/pending config plus k = enabled cycles elapsed in the current PWM period.
  int   m_presc, m_period, m_duty[CH], p_presc, p_period, p_duty[CH], k;
  bit   m_pend;
  logic [CH-1:0] e_pwm;
  logic          e_tick;

  always #5 clkin = ~clkin;

  pwm_multi_gen dut (
    .clkin(clkin), .rst_n(rst_n), .enable(enable), .load(load),
    .presc_top(presc_top), .period(period), .duty(duty),
    .pwm_out(pwm_out), .period_tick(period_tick), .pending(pending)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_presc = 2500; m_period = 99; p_presc = 0; p_period = 0; m_pend = 0; k = 0;
    for (int i = 0; i < CH; i++) begin m_duty[i] = 0; p_duty[i] = 0; end
  endtask

  task automatic set_cfg(input int ps, input int pr, input int d0, input int d1, input int d2, input int d3);
    presc_top = PRESC_W'(ps);
    period    = CNT_W'(pr);
    duty      = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
  endtask

  task automatic cycle();
    int eff, len;
    bit wrap;
    @(posedge clkin);
    if (!rst_n) begin
      model_reset();
      e_pwm = '0; e_tick = 1'b0;
    end else begin
      eff  = (m_presc == 0) ? 1 : m_presc;
      len  = (m_period + 1) * eff;
      for (int i = 0; i < CH; i++) e_pwm[i] = enable && ((k / eff) < m_duty[i]);
      wrap   = enable && (k == len - 1);
      e_tick = wrap;
      k      = (enable && !wrap) ? k + 1 : 0;
      if (wrap || !enable) begin
        if (load) begin
          m_presc = presc_top; m_period = period;
          for (int i = 0; i < CH; i++) m_duty[i] = duty[i*CNT_W +: CNT_W];
        end else if (m_pend) begin
          m_presc = p_presc; m_period = p_period;
          for (int i = 0; i < CH; i++) m_duty[i] = p_duty[i];
        end
        m_pend = 0;
      end else if (load) begin
        p_presc = presc_top; p_period = period; m_pend = 1;
        for (int i = 0; i < CH; i++) p_duty[i] = duty[i*CNT_W +: CNT_W];
      end
    end
    #1;
    chk("pwm_out", pwm_out, e_pwm);
    chk("period_tick", period_tick, e_tick);
    chk("pending", pending, m_pend);
  endtask

  task automatic run(input int n, output int hi0, output int ticks);
    hi0 = 0; ticks = 0;
    repeat (n) begin
      cycle();
      hi0   += int'(pwm_out[0]);
      ticks += int'(period_tick);
    end
  endtask

  task automatic pulse_load();
    load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    bit f = 0;
    for (int n = 0; n < 200 && !f; n++) begin
      cycle();
      f = period_tick;
    end
    chk(tag, f, 1);
  endtask

  initial begin
    int hi, tk;
    bit f;
    model_reset();
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("reset_pwm", pwm_out, 0);
    chk("reset_tick", period_tick, 0);
    chk("reset_pending", pending, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    run(5, hi, tk);
    // presc 4, period 9, duties 5/0/10/4095 loaded while idle
    set_cfg(4, 9, 5, 0, 10, 4095);
    pulse_load();
    enable = 1'b1;
    run(40, hi, tk);
    run(40, hi, tk);
    chk("s1_high40", hi, 20);
    chk("s1_ticks40", tk, 1);
    run(80, hi, tk);
    chk("s1_ticks80", tk, 2);
    // Mid-period duty change waits for the wrap
    wait_tick("s3_sync");
    run(10, hi, tk);
    set_cfg(4, 9, 2, 0, 10, 4095);
    pulse_load();
    chk("s3_pending_set", pending, 1);
    wait_tick("s3_wrap");
    chk("s3_pending_clr", pending, 0);
    run(40, hi, tk);
    chk("s3_high40", hi, 8);
    // presc 0 treated as 1, period 3, duty 2 -> 1100 pattern
    set_cfg(0, 3, 2, 0, 10, 4095);
    pulse_load();
    wait_tick("s4_wrap");
    run(20, hi, tk);
    chk("s4_high20", hi, 10);
    chk("s4_ticks20", tk, 5);
    // Enable drops while a load is pending
    wait_tick("s5_sync");
    run(1, hi, tk);
    set_cfg(1, 5, 3, 1, 6, 0);
    pulse_load();
    chk("s5_pending_set", pending, 1);
    enable = 1'b0;
    cycle();
    chk("s5_pwm_off", pwm_out, 0);
    chk("s5_pending_clr", pending, 0);
    run(3, hi, tk);
    enable = 1'b1;
    run(12, hi, tk);
    chk("s5_high12", hi, 6);
    chk("s5_ticks12", tk, 2);
    // Randomized loads and enable toggles
    repeat (1500) begin
      load = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        set_cfg($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 9),
                $urandom_range(0, 9), $urandom_range(0, 9),
                ($urandom_range(0, 3) == 0) ? 4095 : $urandom_range(0, 9));
        load = 1'b1;
      end
      if ($urandom_range(0, 40) == 0) enable = ~enable;
      cycle();
    end
    load = 1'b0;
    enable = 1'b1;
    // Async reset mid-pulse
    set_cfg(2, 7, 5, 3, 8, 4095);
    enable = 1'b0;
    pulse_load();
    enable = 1'b1;
    f = 0;
    for (int n = 0; n < 100 && !f; n++) begin
      cycle();
      f = pwm_out[0];
    end
    chk("s7_pulse_seen", f, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s7_async_pwm", pwm_out, 0);
    chk("s7_async_pending", pending, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    run(30, hi, tk);
    chk("s7_duty_reset", hi, 0);
    pulse_load();
    chk("s7_pending_after_rst", pending, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
